// File: rtl/y86_pkg.sv
// Y86-64 pipeline constants and the W-register record shared by every stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_reg_t;

  function automatic w_reg_t w_bubble();
    w_reg_t b;
    b.stat  = SAOK;
    b.icode = INOP;
    b.valE  = '0;
    b.valM  = '0;
    b.dstE  = RNONE;
    b.dstM  = RNONE;
    return b;
  endfunction

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// M-stage inputs, combinational memory results and the W pipeline register.
// Valid/ready: none; every field is sampled once per rising edge, W_stall/W_bubble are the only flow control.
interface memory_stage_if;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  m_stat;
  logic [63:0] m_valM;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic        halted;

  modport master (
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    input  m_stat, m_valM, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted
  );

  modport slave (
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    output m_stat, m_valM, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted
  );
endinterface

// File: rtl/memory_stage_data_mem.sv
// Word-addressed 64-bit data memory: combinational read, clocked write, async clear.
module data_mem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: address check, data memory access and the W pipeline register.
module memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_stage_if.slave  mif
);

  localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic          w_rd;
  logic          w_wr;
  logic [63:0]   w_addr;
  logic          w_addr_ok;
  logic [AW-1:0] w_index;
  logic [63:0]   w_rdata;
  logic          w_we;
  logic [3:0]    w_m_stat;
  logic [63:0]   w_m_valM;
  logic          w_unused_cnd;

  w_reg_t r_w;
  logic   r_halted;

  assign w_rd = is_mem_read(mif.M_icode);
  assign w_wr = is_mem_write(mif.M_icode);

  // ret/popq read through the old stack pointer (valA); everything else uses valE.
  assign w_addr    = ((mif.M_icode == IRET) || (mif.M_icode == IPOPQ)) ? mif.M_valA : mif.M_valE;
  assign w_addr_ok = (w_addr < 64'(DMEM_WORDS));
  assign w_index   = w_addr[AW-1:0];

  assign w_m_stat = ((w_rd || w_wr) && !w_addr_ok) ? SADR : mif.M_stat;
  assign w_m_valM = (w_rd && w_addr_ok) ? w_rdata : 64'd0;

  // Stores are suppressed once anything exceptional is in flight or has retired.
  assign w_we = w_wr && w_addr_ok && (mif.M_stat == SAOK) && !r_halted && (r_w.stat == SAOK);

  assign w_unused_cnd = mif.M_cnd;

  data_mem #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_data_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_addr  (w_index),
    .i_wdata (mif.M_valA),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w      <= w_bubble();
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (mif.W_bubble) begin
        r_w <= w_bubble();
      end else if (!mif.W_stall) begin
        r_w.stat  <= w_m_stat;
        r_w.icode <= mif.M_icode;
        r_w.valE  <= mif.M_valE;
        r_w.valM  <= w_m_valM;
        r_w.dstE  <= mif.M_dstE;
        r_w.dstM  <= mif.M_dstM;
        if (w_m_stat != SAOK) r_halted <= 1'b1;
      end
    end
  end

  assign mif.m_stat  = w_m_stat;
  assign mif.m_valM  = w_m_valM;
  assign mif.W_stat  = r_w.stat;
  assign mif.W_icode = r_w.icode;
  assign mif.W_valE  = r_w.valE;
  assign mif.W_valM  = r_w.valM;
  assign mif.W_dstE  = r_w.dstE;
  assign mif.W_dstM  = r_w.dstM;
  assign mif.halted  = r_halted;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table plus reset/halt/alias sequences.
module tb_memory_stage;
  import y86_pkg::*;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  stat;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        stall;
    logic        bubble;
    logic [3:0]  e_mstat;
    logic [63:0] e_mvalM;
    logic [3:0]  e_wstat;
    logic [3:0]  e_wicode;
    logic [63:0] e_wvalE;
    logic [63:0] e_wvalM;
    logic [3:0]  e_wdstE;
    logic [3:0]  e_wdstM;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  memory_stage_if mif ();

  memory_stage #(.DMEM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic [3:0] icode, input logic [3:0] stat, input logic [63:0] valE,
                       input logic [63:0] valA, input logic [3:0] dstE, input logic [3:0] dstM,
                       input logic stall, input logic bubble);
    mif.M_icode  = icode;
    mif.M_stat   = stat;
    mif.M_cnd    = 1'b0;
    mif.M_valE   = valE;
    mif.M_valA   = valA;
    mif.M_dstE   = dstE;
    mif.M_dstM   = dstM;
    mif.W_stall  = stall;
    mif.W_bubble = bubble;
  endtask

  task automatic check_w(input string nm, input logic [3:0] stat, input logic [3:0] icode,
                         input logic [63:0] valE, input logic [63:0] valM,
                         input logic [3:0] dstE, input logic [3:0] dstM, input logic halted);
    chk({nm, ".W_stat"},  64'(mif.W_stat),  64'(stat));
    chk({nm, ".W_icode"}, 64'(mif.W_icode), 64'(icode));
    chk({nm, ".W_valE"},  mif.W_valE,       valE);
    chk({nm, ".W_valM"},  mif.W_valM,       valM);
    chk({nm, ".W_dstE"},  64'(mif.W_dstE),  64'(dstE));
    chk({nm, ".W_dstM"},  64'(mif.W_dstM),  64'(dstM));
    chk({nm, ".halted"},  64'(mif.halted),  64'(halted));
  endtask

  function automatic vec_t mk(input logic [3:0] icode, input logic [63:0] valE, input logic [63:0] valA,
                              input logic [3:0] dstE, input logic [3:0] dstM,
                              input logic stall, input logic bubble, input logic [63:0] e_mvalM,
                              input logic [3:0] e_wicode, input logic [63:0] e_wvalE,
                              input logic [63:0] e_wvalM, input logic [3:0] e_wdstE,
                              input logic [3:0] e_wdstM);
    vec_t v;
    v.icode = icode;  v.stat = SAOK; v.valE = valE; v.valA = valA;
    v.dstE = dstE;    v.dstM = dstM; v.stall = stall; v.bubble = bubble;
    v.e_mstat = SAOK; v.e_mvalM = e_mvalM;
    v.e_wstat = SAOK; v.e_wicode = e_wicode; v.e_wvalE = e_wvalE; v.e_wvalM = e_wvalM;
    v.e_wdstE = e_wdstE; v.e_wdstM = e_wdstM;
    return v;
  endfunction

  // Drive on the falling edge, check comb outputs 1ns later, W outputs 1ns after the rising edge.
  task automatic run_vec(input string nm, input vec_t v);
    @(negedge clk);
    drive(v.icode, v.stat, v.valE, v.valA, v.dstE, v.dstM, v.stall, v.bubble);
    #1;
    chk({nm, ".m_stat"}, 64'(mif.m_stat), 64'(v.e_mstat));
    chk({nm, ".m_valM"}, mif.m_valM, v.e_mvalM);
    @(posedge clk);
    #1;
    check_w(nm, v.e_wstat, v.e_wicode, v.e_wvalE, v.e_wvalM, v.e_wdstE, v.e_wdstM, 1'b0);
  endtask

  task automatic read_check(input string nm, input logic [63:0] addr, input logic [63:0] exp);
    @(negedge clk);
    drive(IMRMOVQ, SAOK, addr, 64'd0, RNONE, RNONE, 1'b0, 1'b0);
    #1;
    chk({nm, ".m_valM"}, mif.m_valM, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE, 1'b0, 1'b0);
    #12;
    check_w("reset", SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE, 1'b0);
    #1 rst_n = 1'b1;

    // icode, valE, valA, dstE, dstM, stall, bubble, m_valM, W_icode, W_valE, W_valM, W_dstE, W_dstM
    vecs.push_back(mk(IRMMOVQ, 64'd10,  64'hDEAD, RNONE, RNONE, 1'b0, 1'b0, 64'd0,     IRMMOVQ, 64'd10,  64'd0,     RNONE, RNONE));
    vecs.push_back(mk(IMRMOVQ, 64'd10,  64'd0,    RNONE, 4'h3,  1'b0, 1'b0, 64'hDEAD,  IMRMOVQ, 64'd10,  64'hDEAD,  RNONE, 4'h3));
    vecs.push_back(mk(IRMMOVQ, 64'd10,  64'h55,   RNONE, RNONE, 1'b0, 1'b0, 64'd0,     IRMMOVQ, 64'd10,  64'd0,     RNONE, RNONE));
    vecs.push_back(mk(IPOPQ,   64'd11,  64'd10,   4'h4,  4'h5,  1'b0, 1'b0, 64'h55,    IPOPQ,   64'd11,  64'h55,    4'h4,  4'h5));
    vecs.push_back(mk(IPUSHQ,  64'd5,   64'h77,   4'h4,  RNONE, 1'b0, 1'b0, 64'd0,     IPUSHQ,  64'd5,   64'd0,     4'h4,  RNONE));
    vecs.push_back(mk(IMRMOVQ, 64'd5,   64'd0,    RNONE, 4'h6,  1'b0, 1'b0, 64'h77,    IMRMOVQ, 64'd5,   64'h77,    RNONE, 4'h6));
    vecs.push_back(mk(ICALL,   64'd3,   64'h1234, 4'h4,  RNONE, 1'b0, 1'b0, 64'd0,     ICALL,   64'd3,   64'd0,     4'h4,  RNONE));
    vecs.push_back(mk(IRET,    64'd11,  64'd3,    4'h4,  RNONE, 1'b0, 1'b0, 64'h1234,  IRET,    64'd11,  64'h1234,  4'h4,  RNONE));
    vecs.push_back(mk(IRMMOVQ, 64'd255, 64'hABC,  RNONE, RNONE, 1'b0, 1'b0, 64'd0,     IRMMOVQ, 64'd255, 64'd0,     RNONE, RNONE));
    vecs.push_back(mk(IMRMOVQ, 64'd255, 64'd0,    RNONE, 4'h3,  1'b0, 1'b0, 64'hABC,   IMRMOVQ, 64'd255, 64'hABC,   RNONE, 4'h3));
    vecs.push_back(mk(IOPQ,    64'd99,  64'd0,    4'h2,  RNONE, 1'b1, 1'b0, 64'd0,     IMRMOVQ, 64'd255, 64'hABC,   RNONE, 4'h3));
    vecs.push_back(mk(IOPQ,    64'd99,  64'd0,    4'h2,  RNONE, 1'b1, 1'b1, 64'd0,     INOP,    64'd0,   64'd0,     RNONE, RNONE));
    vecs.push_back(mk(IOPQ,    64'd99,  64'd0,    4'h2,  RNONE, 1'b0, 1'b0, 64'd0,     IOPQ,    64'd99,  64'd0,     4'h2,  RNONE));
    vecs.push_back(mk(IMRMOVQ, 64'd10,  64'd0,    RNONE, 4'h7,  1'b1, 1'b0, 64'h55,    IOPQ,    64'd99,  64'd0,     4'h2,  RNONE));
    vecs.push_back(mk(IMRMOVQ, 64'd10,  64'd0,    RNONE, 4'h7,  1'b0, 1'b1, 64'h55,    INOP,    64'd0,   64'd0,     RNONE, RNONE));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Async reset landing between edges while a pushq to word 3 is pending.
    run_vec("pre_rst", mk(IRMMOVQ, 64'd3, 64'h33, RNONE, RNONE, 1'b0, 1'b0, 64'd0, IRMMOVQ, 64'd3, 64'd0, RNONE, RNONE));
    @(negedge clk);
    drive(IPUSHQ, SAOK, 64'd3, 64'h66, 4'h4, RNONE, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_w("async_rst", SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE, 1'b0);
    drive(IMRMOVQ, SAOK, 64'd3, 64'd0, RNONE, RNONE, 1'b0, 1'b0);
    #1;
    chk("async_rst.mem3", mif.m_valM, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_w("post_rst", SAOK, IMRMOVQ, 64'd3, 64'd0, RNONE, RNONE, 1'b0);

    // Store with upper address bits set must fault rather than alias onto word 5.
    run_vec("st5", mk(IRMMOVQ, 64'd5, 64'h77, RNONE, RNONE, 1'b0, 1'b0, 64'd0, IRMMOVQ, 64'd5, 64'd0, RNONE, RNONE));
    @(negedge clk);
    drive(IRMMOVQ, SAOK, 64'h1_0000_0005, 64'hBAD, RNONE, RNONE, 1'b0, 1'b0);
    #1;
    chk("alias.m_stat", 64'(mif.m_stat), 64'(SADR));
    chk("alias.m_valM", mif.m_valM, 64'd0);
    @(posedge clk);
    #1;
    check_w("alias", SADR, IRMMOVQ, 64'h1_0000_0005, 64'd0, RNONE, RNONE, 1'b1);
    read_check("alias.mem5", 64'd5, 64'h77);
    @(negedge clk);
    drive(IPUSHQ, SAOK, 64'd5, 64'h999, 4'h4, RNONE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_w("halt_hold", SADR, IRMMOVQ, 64'h1_0000_0005, 64'd0, RNONE, RNONE, 1'b1);
    read_check("halt_block.mem5", 64'd5, 64'h77);

    // First out-of-range word faults, and later stores are dropped.
    do_reset();
    @(negedge clk);
    drive(IMRMOVQ, SAOK, 64'd256, 64'd0, RNONE, 4'h2, 1'b0, 1'b0);
    #1;
    chk("adr256.m_stat", 64'(mif.m_stat), 64'(SADR));
    chk("adr256.m_valM", mif.m_valM, 64'd0);
    @(posedge clk);
    #1;
    check_w("adr256", SADR, IMRMOVQ, 64'd256, 64'd0, RNONE, 4'h2, 1'b1);
    @(negedge clk);
    drive(IPUSHQ, SAOK, 64'd5, 64'h42, 4'h4, RNONE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    read_check("adr256.mem5", 64'd5, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter DMEM_WORDS, default 256, number of 64-bit data-memory words (word-addressed).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 M_stat  input  4  status of instruction in M (1=AOK, 2=HLT, 3=ADR, 4=INS).
REQ-005 M_icode  input  4  instruction code in M.
REQ-006 M_cnd  input  1  condition flag from execute (carried, unused here).
REQ-007 M_valE  input  64  ALU result / effective address.
REQ-008 M_valA  input  64  store data or stack-read address.
REQ-009 M_dstE, M_dstM  input  4 each  destination registers (4'hF = none).
REQ-010 W_stall, W_bubble  input  1 each  pipeline-control requests for the W register.
REQ-011 m_stat  output  4  combinational status after memory access.
REQ-012 m_valM  output  64  combinational read data.
REQ-013 W_stat, W_icode, W_dstE, W_dstM  output  4 each  registered writeback fields.
REQ-014 W_valE, W_valM  output  64 each  registered writeback values.
REQ-015 halted  output  1  sticky flag: an exceptional status has reached W.

Function
REQ-016 Read icodes: 5 (mrmovq) address M_valE; 9 (ret) and B (popq) address M_valA.
REQ-017 Write icodes: 4 (rmmovq), 8 (call), A (pushq) write M_valA to address M_valE.
REQ-018 Address valid iff address < DMEM_WORDS, compared on all 64 bits (no truncation/wrap).
REQ-019 Read or write with invalid address: m_stat = 3 (ADR), m_valM = 0, no write.
REQ-020 Otherwise m_stat = M_stat.
REQ-021 m_valM = mem[addr] for valid reads, 0 for all non-read icodes.
REQ-022 Write commits at rising edge iff write icode, address valid, M_stat = AOK, halted = 0, W_stat in {AOK}.
REQ-023 Read is combinational from array state before that edge's write; same-cycle read/write to one address cannot occur (one instruction in M).
REQ-024 W register update priority: W_bubble (loads bubble) > W_stall (holds) > normal load.
REQ-025 Normal load: W_stat<=m_stat, W_icode<=M_icode, W_valE<=M_valE, W_valM<=m_valM, W_dstE<=M_dstE, W_dstM<=M_dstM.
REQ-026 Bubble: W_stat=1, W_icode=4'h1 (nop), W_valE=W_valM=0, W_dstE=W_dstM=4'hF.
REQ-027 W_bubble and W_stall both high: bubble wins.
REQ-028 halted sets at the edge where W_stat becomes non-AOK; stays set until reset; once set, W holds (implicit stall) and all writes are blocked.
REQ-029 Latency: memory result visible on W outputs one cycle after inputs presented.

Reset
REQ-030 rst_n low: W fields take bubble values (REQ-026), halted = 0, all memory words = 0, immediately and asynchronously.
REQ-031 Reset asserted mid-write cycle: the write is discarded.
REQ-032 Release: first rising edge after rst_n high performs normal operation.

Structure
REQ-033 Shared package y86_pkg holds icode constants, stat codes (AOK/HLT/ADR/INS), RNONE = 4'hF; used by fetch/decode/execute/memory.
REQ-034 One sub-module data_mem: DMEM_WORDS x 64 array, combinational read port, synchronous write port with enable, async clear.

Verification
REQ-035 rmmovq: M_icode=4, M_valE=10, M_valA=0xDEAD, AOK -> next cycle mem[10]=0xDEAD; following mrmovq valE=10 -> m_valM=0xDEAD, W_valM=0xDEAD.
REQ-036 popq: M_icode=B, M_valA=10 (mem[10]=0x55), M_valE=11 -> m_valM=0x55, W_valE=11, W_valM=0x55.
REQ-037 mrmovq M_valE=256 -> m_stat=3, m_valM=0, W_stat=3 next cycle, halted=1; later pushq valE=5 -> mem[5] unchanged.
REQ-038 W_stall=1 with new inputs -> W outputs unchanged; W_stall=1 and W_bubble=1 -> W_icode=1, W_dstE=W_dstM=F.
REQ-039 Assert rst_n=0 asynchronously during write icode=A, valE=3 -> mem[3]=0, W bubble, halted=0 without clock edge.
REQ-040 Write to M_valE=0x1_0000_0005 (upper bits set) -> ADR, no aliasing into mem[5].
